// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage in front of a combinational ins_mem.
//   Owns the PC, drives it to ins_mem, and captures the returned word into
//   the IF/ID register. Supports stall, branch redirect with flush, and a
//   halt once the PC runs off the end of instruction memory.
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   stall               - hold PC, IF/ID, fetch_count and state
//   branch_taken/target - redirect (target word-aligned); flushes IF/ID
//   ins_in              - instruction word for pc_out (same cycle)
//   pc_out              - registered PC to ins_mem
//   if_id_ins/pc/valid  - IF/ID pipeline register
//   halted              - fetch is parked in HALT
//   fetch_count         - valid instructions latched (wraps at 2^16)
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] NOP_INS   = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] ins_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] END_PC = RESET_PC + 32'(4 * MEM_WORDS);

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        tgt_oob;

  // Misaligned targets are silently forced onto a word boundary.
  assign tgt     = {branch_target[31:2], 2'b00};
  assign pc_inc  = pc_out + 32'd4;
  assign tgt_oob = (tgt >= END_PC) || (tgt < RESET_PC);

  // halted decodes straight from the state register, so it is still a
  // registered output with no path from the inputs.
  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc_out      <= RESET_PC;
      if_id_ins   <= NOP_INS;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 16'd0;
    end else if (branch_taken) begin
      // Redirect wins over stall: the flushed bubble replaces whatever
      // the stalled IF/ID was holding.
      pc_out      <= tgt;
      if_id_ins   <= NOP_INS;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
      state       <= tgt_oob ? HALT : RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_id_ins   <= ins_in;
          if_id_pc    <= pc_out;
          if_id_valid <= 1'b1;
          fetch_count <= fetch_count + 16'd1;
          pc_out      <= pc_inc;
          if (pc_inc == END_PC) state <= HALT;
        end
        HALT: begin
          // PC parks; the last real instruction drains as a bubble.
          if_id_ins   <= NOP_INS;
          if_id_pc    <= 32'd0;
          if_id_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ins_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic [31:0] mem [64];
  int checks = 0;
  int fails  = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ins_in(ins_in), .pc_out(pc_out),
    .if_id_ins(if_id_ins), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory model
  always_comb ins_in = mem[pc_out[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins,
                          input logic [31:0] pc, input logic v);
    chk({tag, ".ins"},   if_id_ins, ins);
    chk({tag, ".pc"},    if_id_pc, pc);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0001 + 32'(i);
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

    // Reset state
    #1;
    chk("rst.pc", pc_out, 32'd0);
    chk_ifid("rst", NOP, 32'd0, 1'b0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.cnt", {16'd0, fetch_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ifid($sformatf("seq%0d", k), 32'hA000_0000 + 32'(k), 32'(4 * (k - 1)), 1'b1);
    end
    chk("seq.pc", pc_out, 32'h10);
    chk("seq.cnt", {16'd0, fetch_count}, 32'd4);

    // Async reset mid-run at pc=0x18, mid-cycle
    step(); step();
    chk("pre_rst.pc", pc_out, 32'h18);
    #2 rst = 1'b1;
    #1;
    chk("arst.pc", pc_out, 32'd0);
    chk_ifid("arst", NOP, 32'd0, 1'b0);
    chk("arst.cnt", {16'd0, fetch_count}, 32'd0);
    chk("arst.halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Stall at pc=0x8
    step(); step();
    chk("pre_stall.pc", pc_out, 32'h8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall.pc", pc_out, 32'h8);
      chk("stall.ins", if_id_ins, 32'hA000_0002);
      chk("stall.cnt", {16'd0, fetch_count}, 32'd2);
    end
    stall = 1'b0;
    step();
    chk_ifid("unstall", 32'hA000_0003, 32'h8, 1'b1);
    chk("unstall.cnt", {16'd0, fetch_count}, 32'd3);

    // Branch with stall, misaligned target
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h25;
    step();
    chk("br.pc", pc_out, 32'h24);
    chk_ifid("br", NOP, 32'd0, 1'b0);
    chk("br.cnt", {16'd0, fetch_count}, 32'd3);
    stall = 1'b0; branch_taken = 1'b0;
    step();
    chk_ifid("br_next", 32'hA000_000A, 32'h24, 1'b1);
    chk("br_next.pc", pc_out, 32'h28);

    // Run to the end of memory
    for (int k = 0; k < 53; k++) step();
    chk("pre_halt.pc", pc_out, 32'hFC);
    chk("pre_halt.halted", {31'd0, halted}, 32'd0);
    chk("pre_halt.cnt", {16'd0, fetch_count}, 32'd57);
    step();
    chk_ifid("last", 32'hA000_0040, 32'hFC, 1'b1);
    chk("last.pc", pc_out, 32'h100);
    chk("last.halted", {31'd0, halted}, 32'd1);
    chk("last.cnt", {16'd0, fetch_count}, 32'd58);

    // Stall right after the last capture keeps it in IF/ID
    stall = 1'b1;
    step(); step();
    chk_ifid("halt_stall", 32'hA000_0040, 32'hFC, 1'b1);
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_ifid("halt", NOP, 32'd0, 1'b0);
      chk("halt.pc", pc_out, 32'h100);
      chk("halt.cnt", {16'd0, fetch_count}, 32'd58);
      chk("halt.halted", {31'd0, halted}, 32'd1);
    end

    // Branch out of HALT back to 0
    branch_taken = 1'b1; branch_target = 32'd0;
    step();
    chk("resume.halted", {31'd0, halted}, 32'd0);
    chk("resume.pc", pc_out, 32'd0);
    chk("resume.valid", {31'd0, if_id_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    chk_ifid("resume_fetch", 32'hA000_0001, 32'd0, 1'b1);
    chk("resume_fetch.cnt", {16'd0, fetch_count}, 32'd59);
    chk("resume_fetch.pc", pc_out, 32'h4);

    // Out-of-range branch
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    chk("oob.pc", pc_out, 32'h200);
    chk("oob.halted", {31'd0, halted}, 32'd1);
    chk("oob.valid", {31'd0, if_id_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    chk("oob2.pc", pc_out, 32'h200);
    chk("oob2.valid", {31'd0, if_id_valid}, 32'd0);
    chk("oob2.cnt", {16'd0, fetch_count}, 32'd59);

    // Async reset while a branch is being requested
    branch_taken = 1'b1; branch_target = 32'h40;
    #2 rst = 1'b1;
    #1;
    chk("rst_br.pc", pc_out, 32'd0);
    chk("rst_br.halted", {31'd0, halted}, 32'd0);
    chk("rst_br.cnt", {16'd0, fetch_count}, 32'd0);
    branch_taken = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
